// File: rtl/vga_tmds_encoder_pkg.sv
// Shared constants, pixel bundle type and 8b/10b helper functions for the
// VGA-to-TMDS encoder.
package vga_tmds_encoder_pkg;

  localparam int unsigned TMDS_W    = 10;
  localparam int unsigned PIX_W     = 8;
  localparam int unsigned DEF_CNT_W = 5;

  localparam logic [TMDS_W-1:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [TMDS_W-1:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [TMDS_W-1:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [TMDS_W-1:0] CTRL_TOKEN_11 = 10'b1010101011;

  typedef struct packed {
    logic [PIX_W-1:0] r;
    logic [PIX_W-1:0] g;
    logic [PIX_W-1:0] b;
    logic             blank;
    logic             hsync;
    logic             vsync;
  } vga_pix_t;

  localparam vga_pix_t VGA_PIX_RST = '{r: '0, g: '0, b: '0,
                                       blank: 1'b1, hsync: 1'b0, vsync: 1'b0};

  function automatic logic [3:0] popcount8(input logic [PIX_W-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + 4'(v[i]);
    return n;
  endfunction

  // Transition-minimising stage: bit 8 set means the XOR chain was used.
  function automatic logic [8:0] tmds_minimize(input logic [PIX_W-1:0] d);
    logic [8:0] qm;
    logic [3:0] n1;
    logic       use_xnor;
    n1       = popcount8(d);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    qm[0]    = d[0];
    for (int i = 1; i < 8; i++) begin
      qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    end
    qm[8] = ~use_xnor;
    return qm;
  endfunction

  function automatic logic [TMDS_W-1:0] ctrl_token(input logic [1:0] c);
    case (c)
      2'b00:   return CTRL_TOKEN_00;
      2'b01:   return CTRL_TOKEN_01;
      2'b10:   return CTRL_TOKEN_10;
      default: return CTRL_TOKEN_11;
    endcase
  endfunction

endpackage

// File: rtl/vga_tmds_encoder_if.sv
// Pixel-in / symbol-out bundle between the retiming stage and the TMDS encoder.
// Passthrough VGA outputs exist only when VGA_PASSTHRU_EN is defined.
interface vga_tmds_encoder_if;
  import vga_tmds_encoder_pkg::*;

  logic [PIX_W-1:0]  R_in;
  logic [PIX_W-1:0]  G_in;
  logic [PIX_W-1:0]  B_in;
  logic              blank_in;
  logic              hsync_in;
  logic              vsync_in;
  logic [TMDS_W-1:0] tmds_red;
  logic [TMDS_W-1:0] tmds_green;
  logic [TMDS_W-1:0] tmds_blue;

`ifdef VGA_PASSTHRU_EN
  logic [PIX_W-1:0]  R_out;
  logic [PIX_W-1:0]  G_out;
  logic [PIX_W-1:0]  B_out;
  logic              blank_out;
  logic              hsync_out;
  logic              vsync_out;

  modport master (output R_in, G_in, B_in, blank_in, hsync_in, vsync_in,
                  input  tmds_red, tmds_green, tmds_blue,
                  input  R_out, G_out, B_out, blank_out, hsync_out, vsync_out);
  modport slave  (input  R_in, G_in, B_in, blank_in, hsync_in, vsync_in,
                  output tmds_red, tmds_green, tmds_blue,
                  output R_out, G_out, B_out, blank_out, hsync_out, vsync_out);
`else
  modport master (output R_in, G_in, B_in, blank_in, hsync_in, vsync_in,
                  input  tmds_red, tmds_green, tmds_blue);
  modport slave  (input  R_in, G_in, B_in, blank_in, hsync_in, vsync_in,
                  output tmds_red, tmds_green, tmds_blue);
`endif

endinterface

// File: rtl/vga_tmds_encoder_channel.sv
// Single TMDS channel: stage 1 transition minimisation, stage 2 DC balancing
// with a signed running-disparity counter; control tokens while blanked.
module tmds_channel_encoder
  import vga_tmds_encoder_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic              pixel_clk,
  input  logic              reset,
  input  logic [PIX_W-1:0]  d,
  input  logic              blank,
  input  logic [1:0]        ctrl,
  output logic [TMDS_W-1:0] q
);

  localparam logic signed [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic signed [CNT_W-1:0] CNT_TWO  = CNT_W'(2);

  logic [8:0]               qm_q;
  logic                     blank_q;
  logic [1:0]               ctrl_q;
  logic signed [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TMDS_W-1:0]        q_d;
  logic [3:0]               n1;
  logic signed [CNT_W-1:0]  diff;
  logic                     qm8;

  // Stage 1 register: minimised word plus aligned blank/ctrl.
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      qm_q    <= '0;
      blank_q <= 1'b1;
      ctrl_q  <= 2'b00;
    end else begin
      qm_q    <= tmds_minimize(d);
      blank_q <= blank;
      ctrl_q  <= ctrl;
    end
  end

  // Stage 2 DC balancing; diff is the n1-n0 imbalance of q_m[7:0].
  always_comb begin
    q_d   = ctrl_token(ctrl_q);
    cnt_d = CNT_ZERO;
    qm8   = qm_q[8];
    n1    = popcount8(qm_q[7:0]);
    diff  = CNT_W'({n1, 1'b0}) - CNT_W'(8);
    if (!blank_q) begin
      if ((cnt_q == CNT_ZERO) || (n1 == 4'd4)) begin
        q_d   = {~qm8, qm8, qm8 ? qm_q[7:0] : ~qm_q[7:0]};
        cnt_d = qm8 ? (cnt_q + diff) : (cnt_q - diff);
      end else if (((cnt_q > CNT_ZERO) && (n1 > 4'd4)) ||
                   ((cnt_q < CNT_ZERO) && (n1 < 4'd4))) begin
        q_d   = {1'b1, qm8, ~qm_q[7:0]};
        cnt_d = cnt_q - diff + (qm8 ? CNT_TWO : CNT_ZERO);
      end else begin
        q_d   = {1'b0, qm8, qm_q[7:0]};
        cnt_d = cnt_q + diff - (qm8 ? CNT_ZERO : CNT_TWO);
      end
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      q     <= CTRL_TOKEN_00;
      cnt_q <= CNT_ZERO;
    end else begin
      q     <= q_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vga_tmds_encoder.sv
// DVI 8b/10b encoder for the three colour channels, sync carried on blue.
// Optional macro VGA_PASSTHRU_EN adds a 2-clock aligned VGA passthrough.
module vga_tmds_encoder
  import vga_tmds_encoder_pkg::*;
#(
  parameter int unsigned CNT_W        = DEF_CNT_W,
  parameter bit          SYNC_ON_BLUE = 1'b1
) (
  input  logic              pixel_clk,
  input  logic              reset,
  vga_tmds_encoder_if.slave bus
);

  logic [1:0] blue_ctrl_c;

  assign blue_ctrl_c = SYNC_ON_BLUE ? {bus.vsync_in, bus.hsync_in} : 2'b00;

  tmds_channel_encoder #(.CNT_W(CNT_W)) u_red (
    .pixel_clk (pixel_clk),
    .reset     (reset),
    .d         (bus.R_in),
    .blank     (bus.blank_in),
    .ctrl      (2'b00),
    .q         (bus.tmds_red)
  );

  tmds_channel_encoder #(.CNT_W(CNT_W)) u_green (
    .pixel_clk (pixel_clk),
    .reset     (reset),
    .d         (bus.G_in),
    .blank     (bus.blank_in),
    .ctrl      (2'b00),
    .q         (bus.tmds_green)
  );

  tmds_channel_encoder #(.CNT_W(CNT_W)) u_blue (
    .pixel_clk (pixel_clk),
    .reset     (reset),
    .d         (bus.B_in),
    .blank     (bus.blank_in),
    .ctrl      (blue_ctrl_c),
    .q         (bus.tmds_blue)
  );

`ifdef VGA_PASSTHRU_EN
  vga_pix_t pix_d, pix1_q, pix2_q;

  assign pix_d = '{r: bus.R_in, g: bus.G_in, b: bus.B_in, blank: bus.blank_in,
                   hsync: bus.hsync_in, vsync: bus.vsync_in};

  // Two-deep delay line keeps the DAC feed aligned with the symbols.
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      pix1_q <= VGA_PIX_RST;
      pix2_q <= VGA_PIX_RST;
    end else begin
      pix1_q <= pix_d;
      pix2_q <= pix1_q;
    end
  end

  assign bus.R_out     = pix2_q.r;
  assign bus.G_out     = pix2_q.g;
  assign bus.B_out     = pix2_q.b;
  assign bus.blank_out = pix2_q.blank;
  assign bus.hsync_out = pix2_q.hsync;
  assign bus.vsync_out = pix2_q.vsync;
`endif

endmodule

// File: tb/tb_vga_tmds_encoder.sv
// Directed and random-data bench for vga_tmds_encoder (SYNC_ON_BLUE=1).
module tb_vga_tmds_encoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  vga_tmds_encoder_if bus ();

  vga_tmds_encoder #(.CNT_W(5), .SYNC_ON_BLUE(1'b1)) dut (
    .pixel_clk (clk),
    .reset     (rst),
    .bus       (bus)
  );

  // Advance one edge and settle, so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic blank, input logic hs, input logic vs,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    bus.blank_in = blank;
    bus.hsync_in = hs;
    bus.vsync_in = vs;
    bus.R_in     = r;
    bus.G_in     = g;
    bus.B_in     = b;
  endtask

  function automatic logic [7:0] ref_decode(input logic [9:0] s);
    logic [7:0] v;
    logic [7:0] d;
    v    = s[9] ? ~s[7:0] : s[7:0];
    d[0] = v[0];
    for (int i = 1; i < 8; i++) d[i] = s[8] ? (v[i] ^ v[i-1]) : ~(v[i] ^ v[i-1]);
    return d;
  endfunction

  function automatic logic [9:0] ref_token(input logic [1:0] c);
    logic [9:0] t;
    case (c)
      2'b00:   t = 10'h354;
      2'b01:   t = 10'h0AB;
      2'b10:   t = 10'h154;
      default: t = 10'h2AB;
    endcase
    return t;
  endfunction

  function automatic int disparity(input logic [9:0] s);
    int n;
    n = 0;
    for (int i = 0; i < 10; i++) n += s[i] ? 1 : -1;
    return n;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({bus.tmds_red, bus.tmds_green, bus.tmds_blue} !== {3{10'h354}}) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: got %h %h %h exp 354 x3", i,
                 bus.tmds_red, bus.tmds_green, bus.tmds_blue);
      end
`ifdef VGA_PASSTHRU_EN
      checks++;
      if ({bus.R_out, bus.G_out, bus.B_out, bus.blank_out} !== {24'h0, 1'b1}) begin
        errors++;
        $display("FAIL reset_passthru: got %h %h %h blank=%b exp 0 0 0 blank=1",
                 bus.R_out, bus.G_out, bus.B_out, bus.blank_out);
      end
`endif
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({bus.tmds_red, bus.tmds_green, bus.tmds_blue} !== {3{10'h354}}) begin
        errors++;
        $display("FAIL reset_blank cyc%0d: got %h %h %h exp 354 x3", i,
                 bus.tmds_red, bus.tmds_green, bus.tmds_blue);
      end
    end
  endtask

  task automatic test_sync_tokens();
    logic [1:0] vh [3];
    logic [9:0] exp_b [3];
    vh[0] = 2'b01; exp_b[0] = 10'h0AB;
    vh[1] = 2'b11; exp_b[1] = 10'h2AB;
    vh[2] = 2'b10; exp_b[2] = 10'h154;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, vh[k][0], vh[k][1], 8'hA5, 8'h5A, 8'h3C);
      tick();
      tick();
      checks++;
      if (bus.tmds_blue !== exp_b[k]) begin
        errors++;
        $display("FAIL sync_blue vh=%b: got %h exp %h", vh[k], bus.tmds_blue, exp_b[k]);
      end
      checks++;
      if ({bus.tmds_red, bus.tmds_green} !== {2{10'h354}}) begin
        errors++;
        $display("FAIL sync_rg vh=%b: got %h %h exp 354 354", vh[k],
                 bus.tmds_red, bus.tmds_green);
      end
    end
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    tick();
    tick();
  endtask

  task automatic test_active_zero();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    tick();
    tick();
    checks++;
    if ({bus.tmds_red, bus.tmds_green, bus.tmds_blue} !== {3{10'h100}}) begin
      errors++;
      $display("FAIL zero_px0: got %h %h %h exp 100 x3",
               bus.tmds_red, bus.tmds_green, bus.tmds_blue);
    end
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    tick();
    checks++;
    if ({bus.tmds_red, bus.tmds_green, bus.tmds_blue} !== {3{10'h3FF}}) begin
      errors++;
      $display("FAIL zero_px1: got %h %h %h exp 3ff x3",
               bus.tmds_red, bus.tmds_green, bus.tmds_blue);
    end
    tick();
    checks++;
    if (bus.tmds_blue !== 10'h354) begin
      errors++;
      $display("FAIL zero_to_blank: got %h exp 354", bus.tmds_blue);
    end
    tick();
  endtask

  task automatic test_active_ff();
    drive(1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF);
    tick();
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    tick();
    checks++;
    if ({bus.tmds_red, bus.tmds_green, bus.tmds_blue} !== {3{10'h200}}) begin
      errors++;
      $display("FAIL ff_px: got %h %h %h exp 200 x3",
               bus.tmds_red, bus.tmds_green, bus.tmds_blue);
    end
    tick();
    tick();
  endtask

  task automatic test_random_stream();
    logic [7:0] cur_r, cur_g, cur_b, prv_r, prv_g, prv_b;
    logic       cur_bl, cur_hs, cur_vs, prv_bl, prv_hs, prv_vs;
    logic [9:0] sym [3];
    logic [7:0] px  [3];
    int         sum [3];
    prv_r = '0; prv_g = '0; prv_b = '0;
    prv_bl = 1'b1; prv_hs = 1'b0; prv_vs = 1'b0;
    for (int c = 0; c < 3; c++) sum[c] = 0;
    for (int i = 0; i < 12500; i++) begin
      cur_r  = 8'($urandom);
      cur_g  = 8'($urandom);
      cur_b  = 8'($urandom);
      cur_bl = (i % 100) >= 80;
      cur_hs = 1'($urandom);
      cur_vs = 1'($urandom);
      drive(cur_bl, cur_hs, cur_vs, cur_r, cur_g, cur_b);
      tick();
      if (i > 0) begin
        sym[0] = bus.tmds_red;   px[0] = prv_r;
        sym[1] = bus.tmds_green; px[1] = prv_g;
        sym[2] = bus.tmds_blue;  px[2] = prv_b;
        if (prv_bl) begin
          for (int c = 0; c < 3; c++) sum[c] = 0;
          checks++;
          if ({sym[0], sym[1]} !== {2{10'h354}}) begin
            errors++;
            $display("FAIL rnd_blank_rg i=%0d: got %h %h exp 354 354", i, sym[0], sym[1]);
          end
          checks++;
          if (sym[2] !== ref_token({prv_vs, prv_hs})) begin
            errors++;
            $display("FAIL rnd_blank_b i=%0d: got %h exp %h", i, sym[2],
                     ref_token({prv_vs, prv_hs}));
          end
        end else begin
          for (int c = 0; c < 3; c++) begin
            checks++;
            if (ref_decode(sym[c]) !== px[c]) begin
              errors++;
              $display("FAIL rnd_decode i=%0d ch%0d: sym %h decodes %h exp %h",
                       i, c, sym[c], ref_decode(sym[c]), px[c]);
            end
            sum[c] += disparity(sym[c]);
            checks++;
            if (sum[c] > 10 || sum[c] < -10) begin
              errors++;
              $display("FAIL rnd_disparity i=%0d ch%0d: running sum %0d exp within +-10",
                       i, c, sum[c]);
            end
          end
        end
`ifdef VGA_PASSTHRU_EN
        checks++;
        if ({bus.R_out, bus.G_out, bus.B_out, bus.blank_out, bus.hsync_out, bus.vsync_out}
            !== {prv_r, prv_g, prv_b, prv_bl, prv_hs, prv_vs}) begin
          errors++;
          $display("FAIL rnd_passthru i=%0d: got %h%h%h %b%b%b exp %h%h%h %b%b%b", i,
                   bus.R_out, bus.G_out, bus.B_out, bus.blank_out, bus.hsync_out,
                   bus.vsync_out, prv_r, prv_g, prv_b, prv_bl, prv_hs, prv_vs);
        end
`endif
      end
      prv_r = cur_r; prv_g = cur_g; prv_b = cur_b;
      prv_bl = cur_bl; prv_hs = cur_hs; prv_vs = cur_vs;
    end
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    tick();
    tick();
  endtask

  task automatic test_reset_midline();
    drive(1'b0, 1'b0, 1'b0, 8'h12, 8'h34, 8'h56);
    tick();
    drive(1'b0, 1'b1, 1'b0, 8'hF0, 8'h0F, 8'h81);
    tick();
    tick();
    drive(1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'h00);
    rst = 1'b1;
    tick();
    checks++;
    if ({bus.tmds_red, bus.tmds_green, bus.tmds_blue} !== {3{10'h354}}) begin
      errors++;
      $display("FAIL midline_reset: got %h %h %h exp 354 x3",
               bus.tmds_red, bus.tmds_green, bus.tmds_blue);
    end
`ifdef VGA_PASSTHRU_EN
    checks++;
    if ({bus.R_out, bus.G_out, bus.B_out, bus.blank_out} !== {24'h0, 1'b1}) begin
      errors++;
      $display("FAIL midline_passthru: got %h %h %h blank=%b exp 0 0 0 blank=1",
               bus.R_out, bus.G_out, bus.B_out, bus.blank_out);
    end
`endif
    rst = 1'b0;
    tick();
    checks++;
    if ({bus.tmds_red, bus.tmds_green, bus.tmds_blue} !== {3{10'h354}}) begin
      errors++;
      $display("FAIL midline_flush: got %h %h %h exp 354 x3",
               bus.tmds_red, bus.tmds_green, bus.tmds_blue);
    end
    tick();
    checks++;
    if ({bus.tmds_red, bus.tmds_green, bus.tmds_blue} !== {10'h200, 10'h200, 10'h100}) begin
      errors++;
      $display("FAIL midline_first_px: got %h %h %h exp 200 200 100",
               bus.tmds_red, bus.tmds_green, bus.tmds_blue);
    end
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    tick();
    tick();
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    test_reset();
    test_sync_tokens();
    test_active_zero();
    test_active_ff();
    test_random_stream();
    test_reset_midline();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
